// File: rtl/arb_pkg.sv
// Shared constants for the packet-locked round-robin arbiter: FSM state encoding
// and an elaboration-time log2 helper used to size select indices.
package arb_pkg;

    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_LOCKED = 1'b1;

    // Ceiling log2, never below 1 so a select port always has at least one bit.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_to_1.sv
// Purely combinational N-to-1 selector over a flat bus; lane i lives at [i*W +: W].
// Out-of-range select values (N not a power of two) yield zero.
module mux_n_to_1
    import arb_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int W     = 8,
    localparam int SEL_W = clog2(N)
) (
    input  logic [SEL_W-1:0] sel,
    input  logic [N*W-1:0]   in_bus,
    output logic [W-1:0]     out
);

    logic [W-1:0] lanes [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign lanes[gi] = in_bus[gi*W +: W];
    end

    always_comb begin
        out = '0;
        for (int i = 0; i < N; i++) begin
            if (sel == SEL_W'(i)) begin
                out = lanes[i];
            end
        end
    end

endmodule

// File: rtl/arbiter_rr_mux.sv
// Round-robin arbiter sharing one N-to-1 datapath between N requesters. The grant
// is locked from the first beat of a packet until the handshake of its last beat.
module arbiter_rr_mux
    import arb_pkg::*;
#(
    parameter  int N     = 2,
    parameter  int W     = 8,
    localparam int SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_valid,
    input  logic [N*W-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic [SEL_W-1:0] grant_sel,
    output logic             busy
);

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N - 1);

    logic             state_reg, state_next;
    logic [SEL_W-1:0] grant_sel_reg, grant_sel_next;
    logic [SEL_W-1:0] last_grant_reg, last_grant_next;
    logic [SEL_W-1:0] winner;
    logic             winner_found;
    int               rr_idx;
    logic [N-1:0]     owner_hot;

    // Priority search starts just after the previous owner and wraps modulo N.
    always_comb begin
        winner       = '0;
        winner_found = 1'b0;
        rr_idx       = 0;
        for (int k = 1; k <= N; k++) begin
            rr_idx = (int'(last_grant_reg) + k) % N;
            if (!winner_found && req_valid[rr_idx]) begin
                winner       = SEL_W'(rr_idx);
                winner_found = 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_owner
        assign owner_hot[gi] = (grant_sel_reg == SEL_W'(gi));
        assign req_ready[gi] = busy & owner_hot[gi] & out_ready;
    end

    mux_n_to_1 #(.N(N), .W(W)) u_data_mux (
        .sel    (grant_sel_reg),
        .in_bus (req_data),
        .out    (out_data)
    );

    mux_n_to_1 #(.N(N), .W(1)) u_last_mux (
        .sel    (grant_sel_reg),
        .in_bus (req_last),
        .out    (out_last)
    );

    assign busy      = (state_reg == ST_LOCKED);
    assign out_valid = busy & (|(req_valid & owner_hot));
    assign grant_sel = grant_sel_reg;

    always_comb begin
        state_next      = state_reg;
        grant_sel_next  = grant_sel_reg;
        last_grant_next = last_grant_reg;
        if (state_reg == ST_IDLE) begin
            if (|req_valid) begin
                state_next     = ST_LOCKED;
                grant_sel_next = winner;
            end
        end else begin
            if (out_valid && out_ready && out_last) begin
                state_next      = ST_IDLE;
                last_grant_next = grant_sel_reg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            grant_sel_reg  <= '0;
            last_grant_reg <= LAST_IDX;
        end else begin
            state_reg      <= state_next;
            grant_sel_reg  <= grant_sel_next;
            last_grant_reg <= last_grant_next;
        end
    end

endmodule

// File: tb/tb_arbiter_rr_mux.sv
// Self-checking bench for arbiter_rr_mux: an N=2 instance fed from per-requester
// beat queues with a scoreboard of expected beats, plus an N=3 instance for wrap-around.
module tb_arbiter_rr_mux;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    typedef struct packed {
        logic       g;
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_ready;
    logic [0:0]  grant_sel;
    logic        busy;

    logic [2:0]  t_req_valid;
    logic [23:0] t_req_data;
    logic [2:0]  t_req_last;
    logic [2:0]  t_req_ready;
    logic        t_out_valid;
    logic [7:0]  t_out_data;
    logic        t_out_last;
    logic        t_out_ready;
    logic [1:0]  t_grant_sel;
    logic        t_busy;

    beat_t rq0[$];
    beat_t rq1[$];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;

    always #5 clk = ~clk;

    arbiter_rr_mux #(.N(2), .W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant_sel (grant_sel),
        .busy      (busy)
    );

    arbiter_rr_mux #(.N(3), .W(8)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .req_valid (t_req_valid),
        .req_data  (t_req_data),
        .req_last  (t_req_last),
        .req_ready (t_req_ready),
        .out_valid (t_out_valid),
        .out_data  (t_out_data),
        .out_last  (t_out_last),
        .out_ready (t_out_ready),
        .grant_sel (t_grant_sel),
        .busy      (t_busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic push_req(input int r, input logic [7:0] d, input logic l);
        beat_t b;
        b = '{d: d, l: l};
        if (r == 0) rq0.push_back(b);
        else        rq1.push_back(b);
    endtask

    task automatic push_exp(input logic g, input logic [7:0] d, input logic l);
        exp_t e;
        e = '{g: g, d: d, l: l};
        exp_q.push_back(e);
    endtask

    task automatic present();
        beat_t b;
        req_valid[0] = (rq0.size() != 0);
        b = (rq0.size() != 0) ? rq0[0] : '0;
        req_data[7:0] = b.d;
        req_last[0]   = b.l;
        req_valid[1] = (rq1.size() != 0);
        b = (rq1.size() != 0) ? rq1[0] : '0;
        req_data[15:8] = b.d;
        req_last[1]    = b.l;
    endtask

    // One clock: drive queue heads, score any handshake, then advance to the next negedge.
    task automatic step();
        exp_t e;
        present();
        #1;
        if (out_valid && out_ready) begin
            $display("beat g=%0d data=%h last=%0d", grant_sel, out_data, out_last);
            chk("hs_ready", 32'(req_ready[grant_sel]), 32'd1);
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_grant", 32'(grant_sel), 32'(e.g));
                chk("sb_data", 32'(out_data), 32'(e.d));
                chk("sb_last", 32'(out_last), 32'(e.l));
            end
            if (grant_sel == 1'b0 && rq0.size() != 0) void'(rq0.pop_front());
            if (grant_sel == 1'b1 && rq1.size() != 0) void'(rq1.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int    ov3[8];
        logic  orp[4];
        rst         = 1'b1;
        out_ready   = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        t_req_valid = '0;
        t_req_data  = {8'h03, 8'h02, 8'h01};
        t_req_last  = 3'b111;
        t_out_ready = 1'b1;
        @(negedge clk);
        do_reset();

        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_grant", 32'(grant_sel), 32'd0);

        // Single-beat packet from requester 0.
        push_req(0, 8'hA5, 1'b1);
        push_exp(1'b0, 8'hA5, 1'b1);
        step();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_grant", 32'(grant_sel), 32'd0);
        chk("t1_out_valid", 32'(out_valid), 32'd1);
        chk("t1_out_data", 32'(out_data), 32'hA5);
        chk("t1_req_ready", 32'(req_ready), 32'b01);
        step();
        chk("t1_release", 32'(busy), 32'd0);

        // Both requesters continuously valid with single-beat packets.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_req(0, 8'h10 + 8'(i), 1'b1);
            push_req(1, 8'h20 + 8'(i), 1'b1);
            push_exp(1'b0, 8'h10 + 8'(i), 1'b1);
            push_exp(1'b1, 8'h20 + 8'(i), 1'b1);
        end
        for (int k = 0; k < 12; k++) begin
            step();
            chk("t2_out_valid", 32'(out_valid), (k % 2 == 0) ? 32'd1 : 32'd0);
            if (k % 2 == 0) chk("t2_grant", 32'(grant_sel), 32'((k / 2) % 2));
        end

        // Three-beat packet from requester 0 while requester 1 waits.
        ov3 = '{1, 1, 1, 0, 1, 0, 0, 0};
        push_req(0, 8'h11, 1'b0);
        push_req(0, 8'h22, 1'b0);
        push_req(0, 8'h33, 1'b1);
        push_req(1, 8'h44, 1'b1);
        push_exp(1'b0, 8'h11, 1'b0);
        push_exp(1'b0, 8'h22, 1'b0);
        push_exp(1'b0, 8'h33, 1'b1);
        push_exp(1'b1, 8'h44, 1'b1);
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t3_out_valid", 32'(out_valid), 32'(ov3[k]));
            if (k < 3) begin
                chk("t3_grant", 32'(grant_sel), 32'd0);
                chk("t3_ready1", 32'(req_ready[1]), 32'd0);
            end
            if (k == 4) chk("t3_grant_next", 32'(grant_sel), 32'd1);
        end

        // Back-pressure during a two-beat packet.
        orp = '{1'b1, 1'b0, 1'b0, 1'b1};
        push_req(0, 8'h55, 1'b0);
        push_req(0, 8'h66, 1'b1);
        push_exp(1'b0, 8'h55, 1'b0);
        push_exp(1'b0, 8'h66, 1'b1);
        step();
        for (int k = 0; k < 4; k++) begin
            out_ready = orp[k];
            present();
            #1;
            chk("t4_out_valid", 32'(out_valid), 32'd1);
            chk("t4_out_data", 32'(out_data), (k == 0) ? 32'h55 : 32'h66);
            step();
        end
        chk("t4_release", 32'(busy), 32'd0);
        out_ready = 1'b1;

        // Reset during beat 2 of a four-beat packet drops it.
        push_req(0, 8'hA1, 1'b0);
        push_req(0, 8'hA2, 1'b0);
        push_req(0, 8'hA3, 1'b0);
        push_req(0, 8'hA4, 1'b1);
        push_exp(1'b0, 8'hA1, 1'b0);
        step();
        step();
        rst       = 1'b1;
        out_ready = 1'b0;
        step();
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        rq0.delete();
        push_req(0, 8'hB1, 1'b1);
        push_req(1, 8'hC1, 1'b1);
        push_exp(1'b0, 8'hB1, 1'b1);
        push_exp(1'b1, 8'hC1, 1'b1);
        step();
        chk("t6_grant", 32'(grant_sel), 32'd0);
        chk("t6_relock", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) step();

        // Wrap-around on the N=3 instance.
        do_reset();
        t_req_valid = 3'b110;
        step();
        chk("t5_busy", 32'(t_busy), 32'd1);
        chk("t5_grant1", 32'(t_grant_sel), 32'd1);
        chk("t5_data1", 32'(t_out_data), 32'h02);
        chk("t5_ready1", 32'(t_req_ready), 32'b010);
        step();
        chk("t5_release", 32'(t_busy), 32'd0);
        t_req_valid = 3'b101;
        step();
        chk("t5_grant2", 32'(t_grant_sel), 32'd2);
        chk("t5_data2", 32'(t_out_data), 32'h03);
        t_req_valid = 3'b000;
        step();

        chk("sb_left", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
